// File: rtl/nibble_alu_seq_pkg.sv
// Shared definitions for the nibble-serial ALU: op encodings, FSM states and
// the nibble-count derivation.
package nibble_alu_seq_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int unsigned nib_count(input int unsigned width);
    return width / 4;
  endfunction

endpackage

// File: rtl/nibble_alu_slice.sv
// Combinational 4-bit slice: carry-lookahead adder plus bitwise AND/OR/XOR.
// Time-multiplexed by nibble_alu_seq across all nibbles of an operand.
module nibble_alu_slice (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] sum_o,
  output logic [3:0] and_o,
  output logic [3:0] or_o,
  output logic [3:0] xor_o,
  output logic       cout_o
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;

  // c[i+1] = g[i] | p[i]&c[i], flattened so every carry depends only on cin.
  assign c[0] = cin_i;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);

  assign sum_o  = p ^ c[3:0];
  assign and_o  = g;
  assign or_o   = a_i | b_i;
  assign xor_o  = p;
  assign cout_o = c[4];

endmodule

// File: rtl/nibble_alu_seq.sv
// Nibble-serial ALU: one 4-bit slice processes an operand pair over WIDTH/4
// cycles, with the carry registered between nibbles.
module nibble_alu_seq
  import nibble_alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             out_zero,
  output logic             out_err
);

  localparam int unsigned NIB  = nib_count(WIDTH);
  localparam int unsigned IDXW = (NIB > 1) ? $clog2(NIB) : 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic             carry_q, carry_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cflag_q, cflag_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             err_q, err_d;

  logic [3:0] a_nib, b_nib;
  logic [3:0] s_sum, s_and, s_or, s_xor;
  logic       s_cout;
  logic [3:0] nib_out;
  logic       op_arith;
  logic       op_legal;
  logic       last_nib;

  nibble_alu_slice u_slice (
    .a_i   (a_nib),
    .b_i   (b_nib),
    .cin_i (carry_q),
    .sum_o (s_sum),
    .and_o (s_and),
    .or_o  (s_or),
    .xor_o (s_xor),
    .cout_o(s_cout)
  );

  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int unsigned i = 0; i < NIB; i++) begin
      if (idx_q == IDXW'(i)) begin
        a_nib = a_q[4*i +: 4];
        b_nib = b_q[4*i +: 4];
      end
    end
  end

  always_comb begin
    nib_out  = '0;
    op_arith = 1'b0;
    op_legal = 1'b1;
    case (op_q)
      OP_ADD, OP_SUB: begin
        nib_out  = s_sum;
        op_arith = 1'b1;
      end
      OP_AND:  nib_out = s_and;
      OP_OR:   nib_out = s_or;
      OP_XOR:  nib_out = s_xor;
      default: op_legal = 1'b0;
    endcase
  end

  assign last_nib = (idx_q == IDXW'(NIB - 1));

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    carry_d  = carry_q;
    idx_d    = idx_q;
    result_d = result_q;
    cflag_d  = cflag_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    err_d    = err_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = (in_op == OP_SUB) ? ~in_b : in_b;
          op_d    = in_op;
          carry_d = (in_op == OP_SUB);
          idx_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        for (int unsigned i = 0; i < NIB; i++) begin
          if (idx_q == IDXW'(i)) result_d[4*i +: 4] = nib_out;
        end
        carry_d = s_cout;
        idx_d   = idx_q + 1'b1;
        if (last_nib) begin
          // Flags are committed only once the top nibble is known, so they
          // keep describing the previous result until this operation ends.
          idx_d   = '0;
          state_d = ST_DONE;
          cflag_d = op_arith & s_cout;
          ovf_d   = op_arith & (a_q[WIDTH-1] == b_q[WIDTH-1])
                  & (nib_out[3] != a_q[WIDTH-1]);
          zero_d  = (result_d == '0);
          err_d   = ~op_legal;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_ADD;
      carry_q  <= 1'b0;
      idx_q    <= '0;
      result_q <= '0;
      cflag_q  <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      carry_q  <= carry_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      cflag_q  <= cflag_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
    end
  end

  assign in_ready   = (state_q == ST_IDLE);
  assign out_valid  = (state_q == ST_DONE);
  assign out_result = result_q;
  assign out_carry  = cflag_q;
  assign out_ovf    = ovf_q;
  assign out_zero   = zero_q;
  assign out_err    = err_q;

endmodule

// File: tb/tb_nibble_alu_seq.sv
// Directed self-checking bench for nibble_alu_seq (WIDTH=32, 8 nibbles).
module tb_nibble_alu_seq;

  localparam int unsigned W   = 32;
  localparam int          NIB = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   in_op = 3'b000;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_result;
  logic         out_carry, out_ovf, out_zero, out_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  nibble_alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_result(out_result),
    .out_carry (out_carry),
    .out_ovf   (out_ovf),
    .out_zero  (out_zero),
    .out_err   (out_err)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        carry;
    logic        ovf;
    logic        zero;
    logic        err;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a request, waits (bounded) for acceptance, then counts edges
  // until out_valid. Leaves the DUT in DONE with out_ready low.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit keep_driving, output int lat);
    int guard;
    in_valid = 1'b1;
    in_op = op;
    in_a = a;
    in_b = b;
    guard = 0;
    while (!in_ready && guard < 30) begin
      tick();
      guard++;
    end
    tick();
    if (keep_driving) begin
      in_a = ~a;
      in_b = a ^ b;
      in_op = 3'b011;
    end else begin
      in_valid = 1'b0;
    end
    lat = 99;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (out_valid) begin
        lat = n;
        break;
      end
      if (keep_driving) in_a = in_a + 32'h1;
    end
    in_valid = 1'b0;
  endtask

  task automatic check_outputs(input string tag, input vec_t v);
    chk({tag, "_result"}, out_result, v.res);
    chk({tag, "_carry"}, {31'b0, out_carry}, {31'b0, v.carry});
    chk({tag, "_ovf"}, {31'b0, out_ovf}, {31'b0, v.ovf});
    chk({tag, "_zero"}, {31'b0, out_zero}, {31'b0, v.zero});
    chk({tag, "_err"}, {31'b0, out_err}, {31'b0, v.err});
  endtask

  task automatic release_done(input string tag, input logic [31:0] held);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_idle_ready"}, {31'b0, in_ready}, 32'd1);
    chk({tag, "_idle_hold"}, out_result, held);
  endtask

  initial begin
    int lat;
    bit seen;
    string tag;
    vec_t v;

    vecs[0]  = '{3'b000, 32'h0000_000F, 32'h0000_0001, 32'h0000_0010, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{3'b000, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{3'b000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{3'b001, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{3'b001, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{3'b001, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{3'b010, 32'hF0F0_A5A5, 32'h0FF0_5A5A, 32'h00F0_0000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{3'b011, 32'hF0F0_A5A5, 32'h0FF0_5A5A, 32'hFFF0_FFFF, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{3'b100, 32'hF0F0_A5A5, 32'h0FF0_5A5A, 32'hFF00_FFFF, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{3'b111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[10] = '{3'b101, 32'h1234_5678, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[11] = '{3'b000, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0, 1'b0, 1'b0, 1'b0};

    // Reset state
    #3;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_result", out_result, 32'd0);
    chk("rst_flags", {28'b0, out_carry, out_ovf, out_zero, out_err}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Table-driven vectors
    for (int i = 0; i < 12; i++) begin
      tag = $sformatf("v%0d", i);
      issue(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, lat);
      chk({tag, "_latency"}, lat, NIB);
      check_outputs(tag, vecs[i]);
      release_done(tag, vecs[i].res);
    end

    // DONE hold with in_valid asserted, operands wiggled during RUN
    issue(3'b000, 32'h0000_0001, 32'h0000_0002, 1'b1, lat);
    chk("hold_latency", lat, NIB);
    in_valid = 1'b1;
    in_op = 3'b000;
    in_a = 32'd10;
    in_b = 32'd20;
    for (int k = 0; k < 5; k++) begin
      tick();
      tag = $sformatf("hold%0d", k);
      chk({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
      chk({tag, "_ready"}, {31'b0, in_ready}, 32'd0);
      chk({tag, "_result"}, out_result, 32'd3);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("hold_release_ready", {31'b0, in_ready}, 32'd1);
    chk("hold_release_valid", {31'b0, out_valid}, 32'd0);
    chk("hold_release_result", out_result, 32'd3);
    tick();
    chk("hold_accept_ready", {31'b0, in_ready}, 32'd0);
    in_valid = 1'b0;
    lat = 99;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (out_valid) begin
        lat = n;
        break;
      end
    end
    chk("hold_next_latency", lat, NIB);
    chk("hold_next_result", out_result, 32'd30);
    release_done("hold_next", 32'd30);

    // Leave nonzero flags behind, then reset mid-RUN
    issue(3'b000, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, lat);
    release_done("prerst", 32'h0);
    in_valid = 1'b1;
    in_op = 3'b000;
    in_a = 32'h1234_5678;
    in_b = 32'h1111_1111;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_result", out_result, 32'd0);
    chk("arst_flags", {28'b0, out_carry, out_ovf, out_zero, out_err}, 32'd0);
    chk("arst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("arst_out_valid", {31'b0, out_valid}, 32'd0);
    seen = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    chk("arst_no_valid", {31'b0, seen}, 32'd0);
    chk("arst_idle_ready", {31'b0, in_ready}, 32'd1);
    v = '{3'b000, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0, 1'b0, 1'b0};
    issue(v.op, v.a, v.b, 1'b0, lat);
    chk("post_rst_latency", lat, NIB);
    check_outputs("post_rst", v);
    release_done("post_rst", 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
